// File: rtl/regbank_write_arbiter.sv
// Two-requester write arbiter that zero-clears NREG registers after reset or on demand, then forwards writes.
// Contention winner: requester 0 always; round-robin when PRIO_ROUND_ROBIN_EN is defined.
module regbank_write_arbiter #(
  parameter int NREG = 5,
  parameter int W    = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  input  logic [2:0]   req0_reg,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [2:0]   req1_reg,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  input  logic         clear_start,
  output logic         wr_en,
  output logic [2:0]   wr_reg,
  output logic [W-1:0] wr_data,
  output logic         busy,
  output logic [1:0]   grant,
  output logic         err,
  output logic [7:0]   conflict_cnt
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [2:0] LAST_IDX = 3'(NREG - 1);
  localparam logic [2:0] RA_IDX   = 3'd7;

  state_t         state_q, state_d;
  logic [2:0]     idx_q, idx_d;
  logic           prio0;
  logic           acc;
  logic           legal;
  logic           stall;
  logic [2:0]     acc_reg;
  logic [W-1:0]   acc_data;

`ifdef PRIO_ROUND_ROBIN_EN
  // rr_q set means requester 1 is owed the next contended grant
  logic rr_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else if (acc) begin
      rr_q <= req0_ready;
    end
  end

  assign prio0 = !rr_q;
`else
  assign prio0 = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          state_d = RUN;
          idx_d   = 3'd0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      RUN: begin
        req0_ready = req0_valid && (!req1_valid || prio0);
        req1_ready = req1_valid && !req0_ready;
        // the transfer of this cycle still completes before the clear begins
        if (clear_start) begin
          state_d = CLEAR;
          idx_d   = 3'd0;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = 3'd0;
      end
    endcase
  end

  assign acc      = req0_ready || req1_ready;
  assign acc_reg  = req1_ready ? req1_reg  : req0_reg;
  assign acc_data = req1_ready ? req1_data : req0_data;
  assign legal    = (int'(acc_reg) < NREG) || (acc_reg == RA_IDX);
  assign stall    = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);
  assign busy     = (state_q == CLEAR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= CLEAR;
      idx_q        <= 3'd0;
      wr_en        <= 1'b0;
      wr_reg       <= 3'd0;
      wr_data      <= '0;
      grant        <= 2'b00;
      err          <= 1'b0;
      conflict_cnt <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant   <= {req1_ready, req0_ready};
      if (state_q == CLEAR) begin
        wr_en   <= 1'b1;
        wr_reg  <= idx_q;
        wr_data <= '0;
      end else if (acc && legal) begin
        wr_en   <= 1'b1;
        wr_reg  <= acc_reg;
        wr_data <= acc_data;
      end else begin
        wr_en <= 1'b0;
      end
      // unimplemented index: consumed so the requester is not stuck, but never written
      if (acc && !legal) begin
        err <= 1'b1;
      end
      if (stall && (conflict_cnt != 8'hFF)) begin
        conflict_cnt <= conflict_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter; expectations follow the build's PRIO_ROUND_ROBIN_EN setting.
module tb_regbank_write_arbiter;

  logic       clock;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_reg, req1_reg;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready;
  logic       clear_start;
  logic       wr_en;
  logic [2:0] wr_reg;
  logic [7:0] wr_data;
  logic       busy;
  logic [1:0] grant;
  logic       err;
  logic [7:0] conflict_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  regbank_write_arbiter #(.NREG(5), .W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_reg     (req0_reg),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_reg     (req1_reg),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .clear_start  (clear_start),
    .wr_en        (wr_en),
    .wr_reg       (wr_reg),
    .wr_data      (wr_data),
    .busy         (busy),
    .grant        (grant),
    .err          (err),
    .conflict_cnt (conflict_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [1:0] exp_grant;
    reset       = 1'b0;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req0_reg    = 3'd0;
    req1_reg    = 3'd0;
    req0_data   = 8'h00;
    req1_data   = 8'h00;
    clear_start = 1'b0;

    // reset state
    #1;
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_reg", 32'(wr_reg), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cnt", 32'(conflict_cnt), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // initial clear: registers 0..4 zeroed on edges 1..5
    for (int i = 0; i < 5; i++) begin
      tick();
      check("clr_wr_en", 32'(wr_en), 32'd1);
      check("clr_wr_reg", 32'(wr_reg), 32'(i));
      check("clr_wr_data", 32'(wr_data), 32'd0);
      check("clr_busy", 32'(busy), (i < 4) ? 32'd1 : 32'd0);
    end
    tick();
    check("idle_wr_en", 32'(wr_en), 32'd0);

    // four cycles of contention
    req0_valid = 1'b1; req0_reg = 3'd1; req0_data = 8'h11;
    req1_valid = 1'b1; req1_reg = 3'd3; req1_data = 8'h33;
    for (int k = 0; k < 4; k++) begin
`ifdef PRIO_ROUND_ROBIN_EN
      exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_grant = 2'b01;
`endif
      #1;
      check("cont_ready0", 32'(req0_ready), 32'(exp_grant[0]));
      check("cont_ready1", 32'(req1_ready), 32'(exp_grant[1]));
      tick();
      check("cont_grant", 32'(grant), 32'(exp_grant));
      check("cont_wr_reg", 32'(wr_reg), exp_grant[0] ? 32'd1 : 32'd3);
      check("cont_wr_data", 32'(wr_data), exp_grant[0] ? 32'h11 : 32'h33);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("cont_cnt", 32'(conflict_cnt), 32'd4);

    // same destination: loser written next, last writer wins
    req0_valid = 1'b1; req0_reg = 3'd2; req0_data = 8'hAA;
    req1_valid = 1'b1; req1_reg = 3'd2; req1_data = 8'hBB;
    #1;
    check("same_ready0", 32'(req0_ready), 32'd1);
    check("same_ready1", 32'(req1_ready), 32'd0);
    tick();
    check("same_first_data", 32'(wr_data), 32'hAA);
    req0_valid = 1'b0;
    #1;
    check("same_ready1b", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    check("same_grant", 32'(grant), 32'd2);
    check("same_wr_reg", 32'(wr_reg), 32'd2);
    check("same_last_data", 32'(wr_data), 32'hBB);
    check("same_cnt", 32'(conflict_cnt), 32'd5);

    // single request from requester 0
    req0_valid = 1'b1; req0_reg = 3'd2; req0_data = 8'hA5;
    #1;
    check("single_ready0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    check("single_wr_en", 32'(wr_en), 32'd1);
    check("single_wr_reg", 32'(wr_reg), 32'd2);
    check("single_wr_data", 32'(wr_data), 32'hA5);
    check("single_grant", 32'(grant), 32'd1);
    tick();
    check("hold_wr_en", 32'(wr_en), 32'd0);
    check("hold_grant", 32'(grant), 32'd0);
    check("hold_wr_reg", 32'(wr_reg), 32'd2);
    check("hold_wr_data", 32'(wr_data), 32'hA5);

    // unimplemented index 5
    req1_valid = 1'b1; req1_reg = 3'd5; req1_data = 8'h55;
    #1;
    check("bad_ready1", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    check("bad_wr_en", 32'(wr_en), 32'd0);
    check("bad_err", 32'(err), 32'd1);
    check("bad_grant", 32'(grant), 32'd2);
    tick();
    check("err_sticky", 32'(err), 32'd1);

    // return-address index 7 forwarded
    req0_valid = 1'b1; req0_reg = 3'd7; req0_data = 8'h3C;
    tick();
    req0_valid = 1'b0;
    check("ra_wr_en", 32'(wr_en), 32'd1);
    check("ra_wr_reg", 32'(wr_reg), 32'd7);
    check("ra_wr_data", 32'(wr_data), 32'h3C);

    // clear_start together with a transfer, then clear with a repeated request mid-way
    req0_valid = 1'b1; req0_reg = 3'd1; req0_data = 8'h77;
    clear_start = 1'b1;
    #1;
    check("cs_ready0", 32'(req0_ready), 32'd1);
    tick();
    clear_start = 1'b0;
    check("cs_wr_en", 32'(wr_en), 32'd1);
    check("cs_wr_reg", 32'(wr_reg), 32'd1);
    check("cs_wr_data", 32'(wr_data), 32'h77);
    check("cs_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) clear_start = 1'b1;
      if (i == 4) req0_valid = 1'b0;
      #1;
      if (i < 4) check("cs_ready_low", 32'(req0_ready), 32'd0);
      tick();
      clear_start = 1'b0;
      check("cs_clr_wr_en", 32'(wr_en), 32'd1);
      check("cs_clr_wr_reg", 32'(wr_reg), 32'(i));
      check("cs_clr_wr_data", 32'(wr_data), 32'd0);
      check("cs_clr_busy", 32'(busy), (i < 4) ? 32'd1 : 32'd0);
    end
    tick();
    check("cs_idle_wr_en", 32'(wr_en), 32'd0);
    check("cs_err_kept", 32'(err), 32'd1);

    // reset asserted while the clear sits at idx 3
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    check("rc_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    check("rc_wr_reg2", 32'(wr_reg), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_wr_en", 32'(wr_en), 32'd0);
    check("mid_rst_wr_reg", 32'(wr_reg), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_cnt", 32'(conflict_cnt), 32'd0);
    #2 reset = 1'b1;
    tick();
    check("restart_wr_en", 32'(wr_en), 32'd1);
    check("restart_wr_reg0", 32'(wr_reg), 32'd0);
    tick();
    check("restart_wr_reg1", 32'(wr_reg), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
